// File: rtl/v35_intc.sv
// v35_intc: external-interrupt controller for the V35 wrapper.
// Owns EXIC0..EXIC2 (SFR 0x4C..0x4E) and ISPR (SFR 0xFC). It detects falling edges on the
// INTP0..2 pins and arbitrates pending sources by priority against the in-service level.
// It then drives a single request/vector pair to the core.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   ce        clock enable; every register advances only when ce=1
//   int_n     INTP2..0 pins, active-low, asynchronous
//   sfr_wr    SFR byte write strobe (qualified by ce)
//   sfr_addr  SFR byte address
//   sfr_din   SFR write data
//   sfr_dout  combinational readback of sfr_addr, 0x00 for addresses not owned here
//   eoi       FINT end-of-interrupt strobe
//   irq       request to core
//   irq_vec   vector number, valid while irq=1
//   irq_ack   core acknowledge (level; its rising edge grants)
module v35_intc #(
    parameter int unsigned VEC_BASE    = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [2:0] int_n,
    input  logic       sfr_wr,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_din,
    output logic [7:0] sfr_dout,
    input  logic       eoi,
    output logic       irq,
    output logic [7:0] irq_vec,
    input  logic       irq_ack
);
    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                 r_state, w_state_d;
    logic [SYNC_STAGES-1:0] r_sync [3];
    logic [2:0]             r_pin_q;      // previous synchroniser output, for edge detect
    logic [2:0]             r_if, r_mk, w_if_d, w_mk_d;
    logic [2:0]             r_pr   [3];
    logic [2:0]             w_pr_d [3];
    logic [7:0]             r_ispr, w_ispr_d;
    logic [1:0]             r_w, w_w_d;
    logic [7:0]             r_vec, w_vec_d;
    logic                   r_irq, w_irq_d;
    logic                   r_ack_d;

    logic [2:0] w_sync_out, w_edge, w_elig;
    logic [3:0] w_lvl;                    // lowest in-service level, 8 when none
    logic       w_any;
    logic [1:0] w_win;
    logic [2:0] w_best;
    logic       w_grant;
    logic       w_ack_rise;

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            w_sync_out[n] = r_sync[n][SYNC_STAGES-1];
        end
    end

    assign w_edge     = r_pin_q & ~w_sync_out;
    assign w_ack_rise = irq_ack & ~r_ack_d;

    always_comb begin
        w_lvl = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (r_ispr[i]) w_lvl = 4'(i);
        end
    end

    // Strict '<' on PR keeps the lowest index on a priority tie.
    always_comb begin
        w_elig = '0;
        w_any  = 1'b0;
        w_win  = 2'd0;
        w_best = 3'd7;
        for (int n = 0; n < 3; n++) begin
            w_elig[n] = r_if[n] & ~r_mk[n] & ({1'b0, r_pr[n]} < w_lvl);
            if (w_elig[n] && (!w_any || r_pr[n] < w_best)) begin
                w_any  = 1'b1;
                w_win  = 2'(n);
                w_best = r_pr[n];
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_w_d     = r_w;
        w_vec_d   = r_vec;
        w_irq_d   = r_irq;
        w_if_d    = r_if;
        w_mk_d    = r_mk;
        w_pr_d    = r_pr;
        w_ispr_d  = r_ispr;
        w_grant   = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_w_d     = w_win;
                    w_vec_d   = 8'(VEC_BASE) + {6'd0, w_win};
                    w_irq_d   = 1'b1;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (w_ack_rise) begin
                    w_grant   = 1'b1;
                    w_irq_d   = 1'b0;
                    w_state_d = StWait;
                end else if (!w_elig[r_w]) begin
                    // Source withdrawn by software before the core took it.
                    w_irq_d   = 1'b0;
                    w_state_d = StIdle;
                end
            end
            StWait: begin
                // Holding off here stops one long ack from granting twice.
                if (!irq_ack) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        // IF: ack clear, then software write, then pin edge (edge always wins).
        if (w_grant) w_if_d[r_w] = 1'b0;
        if (sfr_wr) begin
            for (int n = 0; n < 3; n++) begin
                if (sfr_addr == 8'h4C + 8'(n)) begin
                    w_if_d[n] = sfr_din[7];
                    w_mk_d[n] = sfr_din[6];
                    w_pr_d[n] = sfr_din[2:0];
                end
            end
        end
        w_if_d = w_if_d | w_edge;

        // ISPR: software write, then eoi clears its bit, then a grant sets its level.
        if (sfr_wr && sfr_addr == 8'hFC) w_ispr_d = sfr_din;
        if (eoi && !w_lvl[3]) w_ispr_d[w_lvl[2:0]] = 1'b0;
        if (w_grant) w_ispr_d[r_pr[r_w]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 3; n++) begin
                r_sync[n] <= '1;
                r_pr[n]   <= 3'd7;
            end
            r_pin_q <= 3'b111;
            r_if    <= 3'b000;
            r_mk    <= 3'b111;
            r_ispr  <= 8'h00;
            r_state <= StIdle;
            r_w     <= 2'd0;
            r_vec   <= 8'h00;
            r_irq   <= 1'b0;
            r_ack_d <= 1'b0;
        end else if (ce) begin
            for (int n = 0; n < 3; n++) begin
                r_sync[n] <= {r_sync[n][SYNC_STAGES-2:0], int_n[n]};
                r_pr[n]   <= w_pr_d[n];
            end
            r_pin_q <= w_sync_out;
            r_if    <= w_if_d;
            r_mk    <= w_mk_d;
            r_ispr  <= w_ispr_d;
            r_state <= w_state_d;
            r_w     <= w_w_d;
            r_vec   <= w_vec_d;
            r_irq   <= w_irq_d;
            r_ack_d <= irq_ack;
        end
    end

    always_comb begin
        sfr_dout = 8'h00;
        for (int n = 0; n < 3; n++) begin
            if (sfr_addr == 8'h4C + 8'(n)) sfr_dout = {r_if[n], r_mk[n], 3'b000, r_pr[n]};
        end
        if (sfr_addr == 8'hFC) sfr_dout = r_ispr;
    end

    assign irq     = r_irq;
    assign irq_vec = r_vec;

endmodule

// File: tb/tb_v35_intc.sv
// Bench for v35_intc: directed scenarios with constant expectations, then a randomized run
// checked against a behavioural model of the controller's rules.
module tb_v35_intc;
    localparam int unsigned VEC_BASE    = 24;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_WAIT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic [2:0] int_n = 3'b111;
    logic       sfr_wr = 1'b0;
    logic [7:0] sfr_addr = 8'h00;
    logic [7:0] sfr_din = 8'h00;
    logic [7:0] sfr_dout;
    logic       eoi = 1'b0;
    logic       irq;
    logic [7:0] irq_vec;
    logic       irq_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    v35_intc #(
        .VEC_BASE    (VEC_BASE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .int_n    (int_n),
        .sfr_wr   (sfr_wr),
        .sfr_addr (sfr_addr),
        .sfr_din  (sfr_din),
        .sfr_dout (sfr_dout),
        .eoi      (eoi),
        .irq      (irq),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_exic [3];
    logic [7:0] m_ispr;
    int         m_phase;
    int         m_w;
    logic [7:0] m_vec;
    bit         m_irq;
    bit         m_ack_d;
    logic [2:0] m_pins [$];   // pin samples taken on ce ticks, oldest first

    function automatic int in_service_level();
        for (int i = 0; i < 8; i++) if (m_ispr[i]) return i;
        return 8;
    endfunction

    function automatic bit is_eligible(int n);
        return m_exic[n][7] && !m_exic[n][6] && (int'(m_exic[n][2:0]) < in_service_level());
    endfunction

    function automatic int pick_winner();
        int best = -1;
        for (int n = 0; n < 3; n++) begin
            if (is_eligible(n) && (best < 0 || m_exic[n][2:0] < m_exic[best][2:0])) best = n;
        end
        return best;
    endfunction

    function automatic logic [7:0] model_read(logic [7:0] a);
        if (a >= 8'h4C && a <= 8'h4E) return m_exic[int'(a) - 'h4C];
        if (a == 8'hFC) return m_ispr;
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) m_exic[n] = 8'h47;
        m_ispr  = 8'h00;
        m_phase = PH_IDLE;
        m_w     = 0;
        m_vec   = 8'h00;
        m_irq   = 1'b0;
        m_ack_d = 1'b0;
        m_pins.delete();
        for (int i = 0; i < SYNC_STAGES + 2; i++) m_pins.push_back(3'b111);
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [7:0] nx_exic [3];
        logic [7:0] nx_ispr;
        logic [7:0] nx_vec;
        logic [2:0] hit;
        int         lvl, w, nx_phase, nx_w;
        bit         nx_irq, grant;
        if (reset || !ce) return;
        m_pins.push_back(int_n);
        if (m_pins.size() > SYNC_STAGES + 2) void'(m_pins.pop_front());
        // A pin level seen SYNC_STAGES ticks ago that was high one tick before that is an edge.
        for (int n = 0; n < 3; n++) hit[n] = m_pins[0][n] & ~m_pins[1][n];
        lvl      = in_service_level();
        nx_exic  = m_exic;
        nx_ispr  = m_ispr;
        nx_phase = m_phase;
        nx_w     = m_w;
        nx_vec   = m_vec;
        nx_irq   = m_irq;
        grant    = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                w = pick_winner();
                if (w >= 0) begin
                    nx_w     = w;
                    nx_vec   = 8'(VEC_BASE + w);
                    nx_irq   = 1'b1;
                    nx_phase = PH_REQ;
                end
            end
            PH_REQ: begin
                if (irq_ack && !m_ack_d) begin
                    grant    = 1'b1;
                    nx_irq   = 1'b0;
                    nx_phase = PH_WAIT;
                end else if (!is_eligible(m_w)) begin
                    nx_irq   = 1'b0;
                    nx_phase = PH_IDLE;
                end
            end
            default: if (!irq_ack) nx_phase = PH_IDLE;
        endcase
        if (grant) nx_exic[m_w][7] = 1'b0;
        if (sfr_wr && sfr_addr >= 8'h4C && sfr_addr <= 8'h4E)
            nx_exic[int'(sfr_addr) - 'h4C] = sfr_din & 8'hC7;
        for (int n = 0; n < 3; n++) if (hit[n]) nx_exic[n][7] = 1'b1;
        if (sfr_wr && sfr_addr == 8'hFC) nx_ispr = sfr_din;
        if (eoi && lvl < 8) nx_ispr[lvl] = 1'b0;
        if (grant) nx_ispr[m_exic[m_w][2:0]] = 1'b1;
        m_exic  = nx_exic;
        m_ispr  = nx_ispr;
        m_phase = nx_phase;
        m_w     = nx_w;
        m_vec   = nx_vec;
        m_irq   = nx_irq;
        m_ack_d = irq_ack;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ce       = 1'b1;
        int_n    = 3'b111;
        sfr_wr   = 1'b0;
        sfr_addr = 8'h00;
        sfr_din  = 8'h00;
        eoi      = 1'b0;
        irq_ack  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic sfr_write(logic [7:0] a, logic [7:0] d);
        sfr_wr   = 1'b1;
        sfr_addr = a;
        sfr_din  = d;
        tick();
        sfr_wr   = 1'b0;
    endtask

    task automatic rd(logic [7:0] a, output logic [7:0] d);
        sfr_addr = a;
        #1;
        d = sfr_dout;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        checks++;
        if (irq !== 1'b0 || irq_vec !== 8'h00) begin
            errors++;
            $display("FAIL reset_irq: irq=%b vec=%0d want 0/0", irq, irq_vec);
        end
        for (int n = 0; n < 3; n++) begin
            rd(8'h4C + 8'(n), d);
            checks++;
            if (d !== 8'h47) begin
                errors++;
                $display("FAIL reset_exic%0d: got %h want 47", n, d);
            end
        end
        rd(8'hFC, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_ispr: got %h want 00", d); end
        rd(8'h4F, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL unowned_read: got %h want 00", d); end
    endtask

    task automatic test_edge_latency();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4C, 8'h02);
        int_n[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL early_irq: tick %0d irq=%b", i, irq); end
        end
        rd(8'h4C, d);
        checks++;
        if (d !== 8'h82) begin errors++; $display("FAIL if_latency: exic0=%h want 82", d); end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd24) begin
            errors++;
            $display("FAIL irq_latency: irq=%b vec=%0d want 1/24", irq, irq_vec);
        end
    endtask

    task automatic test_priority_eoi();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4C, 8'h05);
        sfr_write(8'h4E, 8'h01);
        int_n = 3'b010;
        ticks(4);
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd26) begin
            errors++;
            $display("FAIL prio_win: irq=%b vec=%0d want 1/26", irq, irq_vec);
        end
        irq_ack = 1'b1;
        tick();
        rd(8'hFC, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL prio_ispr: got %h want 02", d); end
        rd(8'h4E, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL prio_if2: got %h want 01", d); end
        irq_ack = 1'b0;
        ticks(3);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL nested_block: irq=%b want 0", irq); end
        rd(8'h4C, d);
        checks++;
        if (d !== 8'h85) begin errors++; $display("FAIL pending0: got %h want 85", d); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        rd(8'hFC, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL eoi_clear: got %h want 00", d); end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd24) begin
            errors++;
            $display("FAIL after_eoi: irq=%b vec=%0d want 1/24", irq, irq_vec);
        end
    endtask

    task automatic test_long_ack();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4D, 8'h03);
        sfr_write(8'h4C, 8'h02);
        int_n[1] = 1'b0;
        ticks(4);
        int_n[0] = 1'b0;
        ticks(4);
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd25) begin
            errors++;
            $display("FAIL no_preempt: irq=%b vec=%0d want 1/25", irq, irq_vec);
        end
        irq_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL long_ack_irq: tick %0d irq=1", i); end
        end
        rd(8'hFC, d);
        checks++;
        if (d !== 8'h08) begin errors++; $display("FAIL long_ack_ispr: got %h want 08", d); end
        rd(8'h4C, d);
        checks++;
        if (d !== 8'h82) begin errors++; $display("FAIL long_ack_if0: got %h want 82", d); end
        irq_ack = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rearb_gap: irq=%b want 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd24) begin
            errors++;
            $display("FAIL rearb: irq=%b vec=%0d want 1/24", irq, irq_vec);
        end
    endtask

    task automatic test_mask_drop();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4D, 8'h01);
        int_n[1] = 1'b0;
        ticks(4);
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd25) begin
            errors++;
            $display("FAIL mask_req: irq=%b vec=%0d want 1/25", irq, irq_vec);
        end
        sfr_write(8'h4D, 8'hC1);
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask_drop: irq=%b want 0", irq); end
        rd(8'h4D, d);
        checks++;
        if (d !== 8'hC1) begin errors++; $display("FAIL mask_if1: got %h want c1", d); end
        sfr_write(8'h4D, 8'h81);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL unmask_early: irq=%b want 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd25) begin
            errors++;
            $display("FAIL unmask_req: irq=%b vec=%0d want 1/25", irq, irq_vec);
        end
    endtask

    task automatic test_ack_edge_collision();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4C, 8'h01);
        int_n[0] = 1'b0;
        ticks(4);
        int_n[0] = 1'b1;
        tick();
        int_n[0] = 1'b0;
        ticks(2);
        irq_ack = 1'b1;
        tick();
        rd(8'h4C, d);
        checks++;
        if (d !== 8'h81) begin errors++; $display("FAIL collide_if0: got %h want 81", d); end
        rd(8'hFC, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL collide_ispr: got %h want 02", d); end
        irq_ack = 1'b0;
        ticks(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL collide_block: irq=%b want 0", irq); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd24) begin
            errors++;
            $display("FAIL collide_rereq: irq=%b vec=%0d want 1/24", irq, irq_vec);
        end
    endtask

    task automatic test_ce_hold();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4C, 8'h00);
        int_n[0] = 1'b0;
        ce = 1'b0;
        ticks(6);
        rd(8'h4C, d);
        checks++;
        if (irq !== 1'b0 || d !== 8'h00) begin
            errors++;
            $display("FAIL ce_hold: irq=%b exic0=%h want 0/00", irq, d);
        end
        ce = 1'b1;
        ticks(4);
        checks++;
        if (irq !== 1'b1 || irq_vec !== 8'd24) begin
            errors++;
            $display("FAIL ce_resume: irq=%b vec=%0d want 1/24", irq, irq_vec);
        end
        ce = 1'b0;
        irq_ack = 1'b1;
        ticks(3);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ce_ack_hold: irq=%b want 1", irq); end
        ce = 1'b1;
        irq_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h4C, 8'h03);
        sfr_write(8'hFC, 8'h10);
        int_n[0] = 1'b0;
        ticks(4);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: irq=%b want 1", irq); end
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (irq !== 1'b0 || irq_vec !== 8'h00) begin
            errors++;
            $display("FAIL async_irq: irq=%b vec=%0d want 0/0", irq, irq_vec);
        end
        rd(8'hFC, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL async_ispr: got %h want 00", d); end
        for (int n = 0; n < 3; n++) begin
            rd(8'h4C + 8'(n), d);
            checks++;
            if (d !== 8'h47) begin errors++; $display("FAIL async_exic%0d: got %h want 47", n, d); end
        end
        do_reset();
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [7:0] d, exp;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 3; n++) if ($urandom_range(0, 7) == 0) int_n[n] = ~int_n[n];
            case ($urandom_range(0, 4))
                0:       sfr_addr = 8'h4C;
                1:       sfr_addr = 8'h4D;
                2:       sfr_addr = 8'h4E;
                3:       sfr_addr = 8'hFC;
                default: sfr_addr = 8'($urandom);
            endcase
            sfr_wr  = ($urandom_range(0, 9) == 0);
            sfr_din = 8'($urandom);
            if (sfr_addr == 8'hFC && $urandom_range(0, 1) == 0) sfr_din = 8'h00;
            if (sfr_addr != 8'hFC && $urandom_range(0, 3) != 0) sfr_din[6] = 1'b0;
            eoi = ($urandom_range(0, 9) == 0);
            if (irq_ack) irq_ack = ($urandom_range(0, 2) != 0);
            else irq_ack = m_irq && ($urandom_range(0, 1) == 0);
            tick();
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL rand_irq: step %0d irq=%b want %b", i, irq, m_irq);
            end
            if (m_irq) begin
                checks++;
                if (irq_vec !== m_vec) begin
                    errors++;
                    $display("FAIL rand_vec: step %0d vec=%0d want %0d", i, irq_vec, m_vec);
                end
            end
            exp = model_read(sfr_addr);
            rd(sfr_addr, d);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL rand_read: step %0d addr %h got %h want %h", i, sfr_addr, d, exp);
            end
        end
        sfr_wr  = 1'b0;
        eoi     = 1'b0;
        irq_ack = 1'b0;
        ce      = 1'b1;
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority_eoi();
        test_long_ack();
        test_mask_drop();
        test_ack_edge_collision();
        test_ce_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
